// File: rtl/bit_index_decoder.sv
// bit_index_decoder: index-to-one-hot decoder with a 2-entry skid output buffer.
// Optional thermometer mask output is enabled by defining BIT_INDEX_DECODER_THERMO_EN.
module bit_index_decoder #(
  parameter int DOUT_WIDTH = 32,
  parameter int DIN_WIDTH  = $clog2(DOUT_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_zero,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  range_err
`ifdef BIT_INDEX_DECODER_THERMO_EN
  ,
  output logic [DOUT_WIDTH-1:0] dout_mask
`endif
);
  logic [DOUT_WIDTH-1:0] onehot;
  logic [DOUT_WIDTH-1:0] dout_q, dout_d, skid_q, skid_d;
  logic                  dout_valid_q, dout_valid_d, skid_valid_q, skid_valid_d;
  logic                  din_ready_q, range_err_q, range_err_d;
  logic                  in_range, accept, drain, load_out, load_skid;
  always_comb begin
    onehot = '0;
    for (int i = 0; i < DOUT_WIDTH; i++) onehot[i] = !din_zero && (32'(din) == i);
  end
  // An index that lands on no output bit is out of range.
  assign in_range  = |onehot;
  assign accept    = din_valid && din_ready_q;
  assign drain     = dout_valid_q && dout_ready;
  assign load_out  = !dout_valid_q || drain;
  assign load_skid = accept && dout_valid_q && !drain;
  always_comb begin
    dout_d       = load_out ? (skid_valid_q ? skid_q : onehot) : dout_q;
    dout_valid_d = load_out ? (skid_valid_q || accept) : 1'b1;
    skid_d       = load_skid ? onehot : skid_q;
    skid_valid_d = load_skid || (skid_valid_q && !drain);
    range_err_d  = range_err_q || (accept && !din_zero && !in_range);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      skid_q       <= '0;
      dout_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      din_ready_q  <= 1'b1;
      range_err_q  <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      skid_q       <= skid_d;
      dout_valid_q <= dout_valid_d;
      skid_valid_q <= skid_valid_d;
      din_ready_q  <= !skid_valid_d;
      range_err_q  <= range_err_d;
    end
  end
  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign range_err  = range_err_q;
`ifdef BIT_INDEX_DECODER_THERMO_EN
  logic [DOUT_WIDTH-1:0] thermo, mask_q, mask_d, skid_mask_q, skid_mask_d;
  assign thermo = in_range ? (onehot | (onehot - 1'b1)) : '0;
  always_comb begin
    mask_d      = load_out ? (skid_valid_q ? skid_mask_q : thermo) : mask_q;
    skid_mask_d = load_skid ? thermo : skid_mask_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '0;
      skid_mask_q <= '0;
    end else begin
      mask_q      <= mask_d;
      skid_mask_q <= skid_mask_d;
    end
  end
  assign dout_mask = mask_q;
`endif
endmodule

// File: doc/bit_index_decoder.md
BIT_INDEX_DECODER -- requirements
Module: bit_index_decoder

Interface
REQ-001 SHALL have parameter DOUT_WIDTH, default 32: width of the decoded one-hot vector.
REQ-002 SHALL have parameter DIN_WIDTH, default $clog2(DOUT_WIDTH): width of the bit-index input.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port din, input, DIN_WIDTH: bit index to decode.
REQ-006 SHALL have port din_zero, input, 1: marks the source vector as all-zero; forces a zero result.
REQ-007 SHALL have port din_valid, input, 1: din and din_zero are valid.
REQ-008 SHALL have port din_ready, output, 1: block can accept an input.
REQ-009 SHALL have port dout, output, DOUT_WIDTH: one-hot decoded vector.
REQ-010 SHALL have port dout_valid, output, 1: dout is valid.
REQ-011 SHALL have port dout_ready, input, 1: the downstream block accepts dout.
REQ-012 SHALL have port range_err, output, 1: sticky flag for an out-of-range index.

Function
REQ-013 SHALL accept an input on any clock edge where din_valid and din_ready are both 1, and on no other edge.
REQ-014 SHALL transfer an output on any clock edge where dout_valid and dout_ready are both 1.
REQ-015 SHALL decode an accepted input as follows: if din_zero=1, the result is all zeros; otherwise the result has only bit din set.
REQ-016 SHALL treat din >= DOUT_WIDTH with din_zero=0 as out of range: the result is all zeros and range_err is set to 1 on the acceptance edge.
REQ-017 SHALL keep range_err at 1 until reset, once it has been set.
REQ-018 SHALL have a latency of 1 cycle: an input accepted at edge N, with the output stage empty or draining at N, is presented with dout_valid=1 after edge N.
REQ-019 SHALL buffer results in two registered stages, an output register and a skid register; the state is encoded by their valid bits, giving EMPTY, ONE or FULL.
REQ-020 SHALL apply these transitions:
- EMPTY + accept -> ONE.
- ONE + accept, no drain -> FULL.
- ONE + drain, no accept -> EMPTY.
- ONE + accept + drain -> ONE, with the new data in the output register.
- FULL + drain -> ONE, with the skid data moved to the output register.
REQ-021 SHALL drive din_ready as a register equal to NOT skid_valid; it SHALL NOT depend combinationally on dout_ready.
REQ-022 SHALL hold dout stable while dout_valid=1 and dout_ready=0.
REQ-023 SHALL lose no data and duplicate no data under any din_valid/dout_ready pattern.
REQ-024 SHALL sustain a throughput of one result per cycle when dout_ready is held at 1.
REQ-025 SHALL order outputs in the same order as the inputs were accepted.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set dout=0, dout_valid=0, skid_valid=0, range_err=0 and din_ready=1 on that edge.
REQ-027 SHALL discard all buffered results when reset is asserted mid-operation, and SHALL ignore any handshake in that same cycle.
REQ-028 SHALL be able to accept input on the first edge after rst falls.

Configuration
REQ-029 SHALL use the macro BIT_INDEX_DECODER_THERMO_EN.
REQ-030 SHALL, when BIT_INDEX_DECODER_THERMO_EN is defined, add output dout_mask (DOUT_WIDTH bits), a thermometer code with bits 0..din set. It is all zeros for din_zero or an out-of-range index, is buffered alongside dout, and resets to 0.
REQ-031 SHALL, when BIT_INDEX_DECODER_THERMO_EN is not defined, have no dout_mask port and no mask registers.

Verification
REQ-032 SHALL cover reset then single decode: DOUT_WIDTH=32, din=5, din_zero=0, one valid cycle, dout_ready=1 -> next cycle dout=0x00000020, dout_valid=1.
REQ-033 SHALL cover the zero flag: din=7, din_zero=1 -> dout=0x00000000, dout_valid=1, range_err=0.
REQ-034 SHALL cover backpressure: dout_ready=0 while inputs 1, 2, 3 are offered.
- Expected: 1 and 2 accepted; din_ready=0 after the second acceptance; dout holds 0x2.
- Then dout_ready=1 -> outputs 0x2, 0x4, 0x8 in order.
REQ-035 SHALL cover streaming: din = 0..31 on consecutive cycles with dout_ready=1 -> 32 consecutive outputs 1<<i, with din_ready never 0.
REQ-036 SHALL cover out of range: DOUT_WIDTH=24, din=30 -> dout=0 and range_err=1, which stays 1 after a following valid din=3 (dout=0x000008).
REQ-037 SHALL cover mid-operation reset: reset with the block FULL -> next cycle dout_valid=0, din_ready=1, range_err=0; with THERMO_EN defined, din=3 after reset -> dout_mask=0x0000000F.
